serial_adder: RTL

Parametrised bit-serial adder/subtractor, the sequential successor to the team's combinational half adder. It accepts two WIDTH-bit operands with a start/ready handshake and adds them LSB-first, one bit per clock, through a single full-adder cell with a registered carry. It then presents the registered sum, carry-out and signed-overflow with a one-cycle done pulse. It serves area-constrained datapaths where a WIDTH-bit parallel adder is too large.

---
 rtl/serial_adder_if.sv | 25 ++
 rtl/serial_adder.sv | 136 +++++++++++++
 2 files changed

// File: rtl/serial_adder_if.sv
// Handshake and result bundle for the bit-serial adder/subtractor.
// The master side issues operations; the slave side (the adder) returns results.
interface serial_adder_if #(
    parameter int unsigned WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sub;
    logic             ready;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             co;
    logic             ovf;

    modport master (
        output start, a, b, sub,
        input  ready, done, sum, co, ovf
    );

    modport slave (
        input  start, a, b, sub,
        output ready, done, sum, co, ovf
    );
endinterface

// File: rtl/serial_adder.sv
// Bit-serial adder/subtractor: one full-adder cell with a registered carry
// processes the operands LSB-first, one bit per clock. Results are published
// only when the last bit completes, together with a one-cycle done pulse.
module serial_adder #(
    parameter int unsigned WIDTH = 8
) (
    input logic           clk,
    input logic           rst,
    serial_adder_if.slave bus
);

    localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    state_e state_q, state_d;

    // Operand shift registers; B is stored pre-inverted for subtraction.
    logic [WIDTH-1:0] sa_q, sa_d;
    logic [WIDTH-1:0] sb_q, sb_d;
    // Holds the first WIDTH-1 result bits; the final bit joins on completion.
    logic [WIDTH-2:0] res_q, res_d;
    logic             c_q, c_d;
    logic [CntW-1:0]  cnt_q, cnt_d;

    // Published result registers, written only on completion.
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             co_q, co_d;
    logic             ovf_q, ovf_d;

    // Full-adder cell outputs for the current bit position.
    logic s_bit;
    logic c_next;
    logic last_bit;

    // Single full-adder cell acting on the LSBs of the operand registers.
    always_comb begin
        s_bit    = sa_q[0] ^ sb_q[0] ^ c_q;
        c_next   = (sa_q[0] & sb_q[0]) | (sa_q[0] & c_q) | (sb_q[0] & c_q);
        last_bit = (cnt_q == LastCnt);
    end

    // Next-state logic: accept in IDLE, shift one bit per RUN cycle, publish on the last bit.
    always_comb begin
        state_d = state_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        res_d   = res_q;
        c_d     = c_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        co_d    = co_q;
        ovf_d   = ovf_q;

        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    sa_d    = bus.a;
                    // A - B is computed as A + ~B + 1; the +1 enters as the initial carry.
                    sb_d    = bus.sub ? ~bus.b : bus.b;
                    c_d     = bus.sub;
                    cnt_d   = '0;
                    res_d   = '0;
                    state_d = StRun;
                end
            end

            StRun: begin
                res_d          = res_q >> 1;
                res_d[WIDTH-2] = s_bit;
                sa_d           = sa_q >> 1;
                sb_d           = sb_q >> 1;
                c_d            = c_next;
                if (last_bit) begin
                    // Hold the counter so it never wraps past WIDTH-1.
                    cnt_d   = cnt_q;
                    sum_d   = {s_bit, res_q};
                    co_d    = c_next;
                    // c_q here is the carry into the MSB.
                    ovf_d   = c_q ^ c_next;
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            StDone: begin
                state_d = StIdle;
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and datapath registers with asynchronous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            sa_q    <= '0;
            sb_q    <= '0;
            res_q   <= '0;
            c_q     <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            co_q    <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            res_q   <= res_d;
            c_q     <= c_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            co_q    <= co_d;
            ovf_q   <= ovf_d;
        end
    end

    // Outputs come straight from registers; start has no path to them.
    always_comb begin
        bus.ready = (state_q == StIdle);
        bus.done  = (state_q == StDone);
        bus.sum   = sum_q;
        bus.co    = co_q;
        bus.ovf   = ovf_q;
    end

endmodule
